// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_pkg
//  Purpose  : Shared RV32I encodings for the memory/writeback stage:
//             operation kinds, load/store funct3 values, stage states.
//  Revision : 1.0  initial release
// ============================================================================
package rv32_pkg;

  // Operation kind handed over from execute
  localparam logic [1:0] OP_ALU   = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_NONE  = 2'd3;

  // Load widths
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store widths
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Stage state: accepting new work, or waiting on the data memory
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } wb_state_t;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_align
//  Purpose  : Combinational helpers for the memory stage: legality/alignment
//             fault check and store strobe/replication for the operation
//             being accepted, plus load lane extraction and extension for
//             the operation in flight.
//  Revision : 1.0  initial release
// ============================================================================
module mem_align
  import rv32_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic        fault,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Fault: illegal width encoding or address not aligned to the access size
  always_comb begin
    fault = 1'b0;
    if (op == OP_LOAD) begin
      case (funct3)
        F3_LB, F3_LBU: fault = 1'b0;
        F3_LH, F3_LHU: fault = addr_lo[0];
        F3_LW:         fault = (addr_lo != 2'b00);
        default:       fault = 1'b1;
      endcase
    end else if (op == OP_STORE) begin
      case (funct3)
        F3_SB:   fault = 1'b0;
        F3_SH:   fault = addr_lo[0];
        F3_SW:   fault = (addr_lo != 2'b00);
        default: fault = 1'b1;
      endcase
    end
  end

  // Store: byte enables follow the addressed lanes, data replicated across lanes
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = 32'd0;
    case (funct3)
      F3_SB: begin
        st_wstrb = 4'b0001 << addr_lo;
        st_wdata = {4{store_data[7:0]}};
      end
      F3_SH: begin
        st_wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      F3_SW: begin
        st_wstrb = 4'b1111;
        st_wdata = store_data;
      end
      default: begin
        st_wstrb = 4'b0000;
        st_wdata = 32'd0;
      end
    endcase
  end

  // Load: pick the addressed lane and sign- or zero-extend it
  always_comb begin
    ld_byte = 8'd0;
    ld_half = 16'd0;
    ld_data = rdata;
    case (ld_addr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data = {24'd0, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule : mem_align
`default_nettype wire

// File: rtl/mem_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : mem_writeback
//  Purpose  : RV32I memory-access and writeback stage. Sole driver of the
//             register file write port; address 0 means "no write".
//  Revision : 1.0  initial release
// ============================================================================
module mem_writeback
  import rv32_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_result,
  input  logic [31:0] i_store_data,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic        o_fault
);

  wb_state_t   state;
  logic [4:0]  lat_rd;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_addr_lo;
  logic        lat_is_load;

  logic        acc_fault;
  logic [3:0]  acc_wstrb;
  logic [31:0] acc_wdata;
  logic [31:0] ld_data;

  // Ready is combinational so execute sees the stage free in the cycle after an ack
  assign o_ready = !i_rst && (state == ST_IDLE);

  mem_align u_align (
    .op         (i_op),
    .funct3     (i_funct3),
    .addr_lo    (i_result[1:0]),
    .store_data (i_store_data),
    .ld_funct3  (lat_funct3),
    .ld_addr_lo (lat_addr_lo),
    .rdata      (i_mem_rdata),
    .fault      (acc_fault),
    .st_wstrb   (acc_wstrb),
    .st_wdata   (acc_wdata),
    .ld_data    (ld_data)
  );

  // Stage FSM with registered memory, writeback and fault outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      lat_rd      <= 5'd0;
      lat_funct3  <= 3'd0;
      lat_addr_lo <= 2'd0;
      lat_is_load <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= 32'd0;
      o_mem_wdata <= 32'd0;
      o_mem_wstrb <= 4'd0;
      o_rf_waddr  <= 5'd0;
      o_rf_wdata  <= 32'd0;
      o_fault     <= 1'b0;
    end else begin
      // Writeback and fault are single-cycle events unless set below
      o_rf_waddr <= 5'd0;
      o_rf_wdata <= 32'd0;
      o_fault    <= 1'b0;

      if (state == ST_IDLE) begin
        if (i_valid) begin
          if (i_op == OP_ALU) begin
            o_rf_waddr <= i_rd;
            o_rf_wdata <= (i_rd == 5'd0) ? 32'd0 : i_result;
          end else if (i_op == OP_LOAD || i_op == OP_STORE) begin
            if (acc_fault) begin
              o_fault <= 1'b1;
            end else begin
              lat_rd      <= i_rd;
              lat_funct3  <= i_funct3;
              lat_addr_lo <= i_result[1:0];
              lat_is_load <= (i_op == OP_LOAD);
              o_mem_req   <= 1'b1;
              o_mem_we    <= (i_op == OP_STORE);
              o_mem_addr  <= {i_result[31:2], 2'b00};
              o_mem_wdata <= (i_op == OP_STORE) ? acc_wdata : 32'd0;
              o_mem_wstrb <= (i_op == OP_STORE) ? acc_wstrb : 4'd0;
              state       <= ST_MEM;
            end
          end
        end
      end else begin
        if (i_mem_ack) begin
          o_mem_req   <= 1'b0;
          o_mem_we    <= 1'b0;
          o_mem_addr  <= 32'd0;
          o_mem_wdata <= 32'd0;
          o_mem_wstrb <= 4'd0;
          if (lat_is_load && lat_rd != 5'd0) begin
            o_rf_waddr <= lat_rd;
            o_rf_wdata <= ld_data;
          end
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule : mem_writeback
`default_nettype wire

// File: tb/tb_mem_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_writeback
//  Purpose  : Self-checking bench for mem_writeback: directed scenarios plus
//             randomized operations compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_writeback;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [1:0]  op;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] result;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_writeback dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .o_ready      (ready),
    .i_op         (op),
    .i_funct3     (funct3),
    .i_rd         (rd),
    .i_result     (result),
    .i_store_data (store_data),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_wstrb  (mem_wstrb),
    .i_mem_ack    (mem_ack),
    .i_mem_rdata  (mem_rdata),
    .o_rf_waddr   (rf_waddr),
    .o_rf_wdata   (rf_wdata),
    .o_fault      (fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_fault(input logic [1:0] o, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    if (o == OP_ALU || o == OP_NONE) return 1'b0;
    if (o == OP_LOAD  && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if (o == OP_STORE && f3 >= 3'd3) return 1'b1;
    sz = m_size(f3);
    return (int'(addr[1:0]) % sz) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdat);
    int sz, idx;
    logic [31:0] v, mask;
    sz  = m_size(f3);
    idx = int'(addr[1:0]);
    if (sz == 4) return rdat;
    v    = rdat >> (8 * idx);
    mask = (32'h1 << (8 * sz)) - 32'h1;
    v    = v & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] m_strb(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] s;
    int sz, idx;
    s   = '0;
    sz  = m_size(f3);
    idx = int'(addr[1:0]);
    for (int i = 0; i < sz; i++) s[idx+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    int sz;
    sz = m_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  // Present one operation, serve its memory access after `dly` idle cycles, check everything
  task automatic do_op(input logic [1:0] o, input logic [2:0] f3, input logic [4:0] d,
                       input logic [31:0] res, input logic [31:0] sd, input int dly,
                       input logic [31:0] rdat);
    bit flt;
    bit is_st;
    logic [31:0] exp_wd;
    flt   = m_fault(o, f3, res);
    is_st = (o == OP_STORE);
    check_eq("ready_before_accept", {31'd0, ready}, 32'd1);
    valid = 1'b1; op = o; funct3 = f3; rd = d; result = res; store_data = sd;
    mem_ack = 1'($urandom_range(0, 1));   // stray ack while idle must be ignored
    tick();
    valid = 1'b0; mem_ack = 1'b0;
    check_eq("fault", {31'd0, fault}, {31'd0, flt});
    if (o == OP_ALU) begin
      check_eq("alu_waddr", {27'd0, rf_waddr}, {27'd0, d});
      check_eq("alu_wdata", rf_wdata, (d == 5'd0) ? 32'd0 : res);
      check_eq("alu_no_req", {31'd0, mem_req}, 32'd0);
    end else if (o == OP_NONE || flt) begin
      check_eq("nowb_waddr", {27'd0, rf_waddr}, 32'd0);
      check_eq("nowb_wdata", rf_wdata, 32'd0);
      check_eq("nowb_no_req", {31'd0, mem_req}, 32'd0);
      check_eq("nowb_ready", {31'd0, ready}, 32'd1);
    end else begin
      check_eq("req", {31'd0, mem_req}, 32'd1);
      check_eq("we", {31'd0, mem_we}, {31'd0, is_st});
      check_eq("addr", mem_addr, res & ~32'h3);
      check_eq("wstrb", {28'd0, mem_wstrb}, is_st ? m_strb(f3, res) : 32'd0);
      if (is_st) check_eq("wdata", mem_wdata, m_wdata(f3, sd));
      check_eq("busy", {31'd0, ready}, 32'd0);
      for (int k = 0; k < dly; k++) begin
        tick();
        check_eq("req_hold", {31'd0, mem_req}, 32'd1);
        check_eq("addr_hold", mem_addr, res & ~32'h3);
        check_eq("busy_hold", {31'd0, ready}, 32'd0);
        check_eq("no_wb_wait", {27'd0, rf_waddr}, 32'd0);
      end
      mem_ack = 1'b1; mem_rdata = rdat;
      tick();
      mem_ack = 1'b0; mem_rdata = $urandom;
      exp_wd = (!is_st && d != 5'd0) ? m_load(f3, res, rdat) : 32'd0;
      check_eq("req_drop", {31'd0, mem_req}, 32'd0);
      check_eq("ready_after_ack", {31'd0, ready}, 32'd1);
      check_eq("mem_waddr", {27'd0, rf_waddr}, (!is_st) ? {27'd0, d} : 32'd0);
      check_eq("mem_wdata", rf_wdata, exp_wd);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   {31'd0, mem_req}, 32'd0);
    check_eq({tag, "_we"},    {31'd0, mem_we}, 32'd0);
    check_eq({tag, "_addr"},  mem_addr, 32'd0);
    check_eq({tag, "_wdata"}, mem_wdata, 32'd0);
    check_eq({tag, "_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    check_eq({tag, "_waddr"}, {27'd0, rf_waddr}, 32'd0);
    check_eq({tag, "_rfdata"}, rf_wdata, 32'd0);
    check_eq({tag, "_fault"}, {31'd0, fault}, 32'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [2:0]  r_f3;
    logic [31:0] r_res;
    rst = 1'b1; valid = 1'b0; op = OP_NONE; funct3 = 3'd0; rd = 5'd0;
    result = 32'd0; store_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    tick();
    tick();
    check_reset_outputs("reset");
    check_eq("ready_in_reset", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    #1;

    // Directed scenarios
    do_op(OP_ALU, 3'd0, 5'd5, 32'hDEADBEEF, 32'd0, 0, 32'd0);
    do_op(OP_ALU, 3'd0, 5'd6, 32'h0000_1111, 32'd0, 0, 32'd0);
    do_op(OP_ALU, 3'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 0, 32'd0);
    do_op(OP_LOAD,  F3_LB,  5'd7, 32'h0000_1003, 32'd0, 3, 32'h80FF7F01);
    do_op(OP_LOAD,  F3_LBU, 5'd8, 32'h0000_1003, 32'd0, 3, 32'h80FF7F01);
    do_op(OP_STORE, F3_SH,  5'd9, 32'h0000_2002, 32'h1234ABCD, 2, 32'd0);
    do_op(OP_LOAD,  F3_LW,  5'd3, 32'h0000_3001, 32'd0, 0, 32'd0);
    do_op(OP_LOAD,  F3_LW,  5'd0, 32'h0000_4000, 32'd0, 1, 32'hCAFEF00D);
    do_op(OP_LOAD,  F3_LH,  5'd4, 32'h0000_4002, 32'd0, 0, 32'h8001_7FFF);
    do_op(OP_LOAD,  3'b011, 5'd4, 32'h0000_4000, 32'd0, 0, 32'd0);
    do_op(OP_STORE, 3'b100, 5'd4, 32'h0000_4000, 32'd0, 0, 32'd0);
    do_op(OP_NONE,  3'd0,   5'd12, 32'h1234_5678, 32'd0, 0, 32'd0);

    // Reset while a request is outstanding
    valid = 1'b1; op = OP_LOAD; funct3 = F3_LW; rd = 5'd10; result = 32'h0000_5000;
    tick();
    valid = 1'b0;
    check_eq("pre_rst_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
    tick();
    mem_ack = 1'b0;
    check_eq("late_ack_waddr", {27'd0, rf_waddr}, 32'd0);
    check_eq("late_ack_req", {31'd0, mem_req}, 32'd0);
    do_op(OP_ALU, 3'd0, 5'd11, 32'h0BAD_F00D, 32'd0, 0, 32'd0);

    // Randomized operations
    for (int n = 0; n < 300; n++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_f3  = 3'($urandom_range(0, 7));
      r_res = $urandom;
      if ($urandom_range(0, 9) < 6) r_res = r_res & ~32'h3;
      do_op(r_op, r_f3, 5'($urandom_range(0, 31)), r_res, $urandom,
            $urandom_range(0, 3), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_writeback
`default_nettype wire

// File: doc/mem_writeback.md
# mem_writeback

Memory-access and writeback stage of the RV32I core; the single writer of the register file's write port. Accepts retired operations from execute over a valid/ready handshake, performs LB/LH/LW/LBU/LHU/SB/SH/SW via a req/ack data-memory port, aligns and sign-extends load data, and drives the register file write address/data. The register file has no write enable, so "no write" is expressed by driving write address 0.

## Interface
- Parameters: none; datapath fixed at 32 bits.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  execute presents an operation.
- o_ready  out  1  stage can accept; transfer when i_valid && o_ready.
- i_op  in  2  0=ALU (write i_result), 1=LOAD, 2=STORE, 3=NONE (no memory access, no writeback).
- i_funct3  in  3  RV32I load/store width field.
- i_rd  in  5  destination register.
- i_result  in  32  ALU result, or effective address for LOAD/STORE.
- i_store_data  in  32  rs2 value for STORE.
- o_mem_req  out  1  memory request, held until ack.
- o_mem_we  out  1  1=write.
- o_mem_addr  out  32  word address (bits[1:0]=0).
- o_mem_wdata  out  32  lane-replicated store data.
- o_mem_wstrb  out  4  byte enables (0 for reads).
- i_mem_ack  in  1  request complete; i_mem_rdata valid this cycle.
- i_mem_rdata  in  32  read data.
- o_rf_waddr  out  5  register file write address; 0 = no write.
- o_rf_wdata  out  32  register file write data; 0 when o_rf_waddr=0.
- o_fault  out  1  one-cycle pulse: misaligned address or illegal funct3.

## Operation
- FSM states: IDLE, MEM. o_ready = !i_rst && state==IDLE.
- IDLE, ALU accepted: next cycle o_rf_waddr=i_rd, o_rf_wdata=i_result (0 if i_rd=0); stay IDLE.
- IDLE, NONE accepted: next cycle o_rf_waddr=0; stay IDLE.
- IDLE, LOAD/STORE accepted, legal: latch rd, funct3, addr[1:0], store data; go MEM; o_mem_req=1 next cycle.
- MEM: hold o_mem_req/we/addr/wdata/wstrb stable until i_mem_ack; on ack return IDLE; LOAD: next cycle o_rf_waddr=rd, o_rf_wdata=aligned data.
- Load align: byte lane = addr[1:0]; half lane = addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
- Store: SB wstrb=4'b0001<<addr[1:0], wdata={4{byte}}; SH wstrb=addr[1]?1100:0011, wdata={2{half}}; SW wstrb=1111.
- Fault: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; LOAD funct3 in {011,110,111}; STORE funct3 >=011. Next cycle o_fault=1, o_rf_waddr=0, no memory request; stay IDLE.
- LOAD with rd=0: memory read performed; writeback suppressed (o_rf_waddr=0).
- i_mem_ack in IDLE is ignored.

## Timing
- Reset values: o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_mem_wstrb=0, o_rf_waddr=0, o_rf_wdata=0, o_fault=0; state=IDLE.
- All outputs except o_ready are registered.
- ALU/NONE: accept cycle N, rf write visible in N+1, captured by the register file at the end of N+1; throughput 1/cycle.
- LOAD: accept N, o_mem_req from N+1, ack at M>=N+1 (same-cycle ack allowed), rf write in M+1, o_ready high again in M+1.
- STORE: as LOAD, with no rf write; o_ready high in M+1.
- o_rf_waddr returns to 0 in every cycle that has no writeback; one write per cycle.
- Reset mid-MEM: request abandoned, o_mem_req=0 the cycle after i_rst is sampled high; any late ack is ignored.

## Structure
- Shared package rv32_pkg: op encodings (OP_ALU/LOAD/STORE/NONE) and funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW).
- One combinational sub-module, mem_align: load extract/extend and store strobe/replicate, plus the fault check.

## Test plan
- ALU rd=5, result 0xDEADBEEF at N -> o_rf_waddr=5, o_rf_wdata=0xDEADBEEF in N+1; back-to-back ALU ops each written in consecutive cycles.
- LB addr 0x1003, rdata 0x80FF7F01, ack 3 cycles after req -> o_mem_addr=0x1000, wstrb=0, rd gets 0xFFFFFF80 in the cycle after ack; LBU same -> 0x00000080.
- SH addr 0x2002, data 0x1234ABCD -> wstrb=1100, wdata=0xABCDABCD, no rf write, o_ready low until the cycle after ack.
- LW addr 0x3001 -> o_fault pulse in N+1, o_mem_req stays 0, o_rf_waddr=0, o_ready stays high.
- LOAD rd=0 with ack -> memory read issued, o_rf_waddr stays 0.
- i_rst asserted while o_mem_req=1 -> o_mem_req=0 next cycle, all outputs at reset values, late ack ignored, next ALU op written normally.
